// File: rtl/fuse_lut_pkg.sv
// Shared types for the FDM fuse LUT walker: LUT row layout, EOF sentinel and walker states.
package fuse_lut_pkg;

   localparam int FDM_DATA_W  = 32;
   localparam int FDM_ADDR_W  = 32;
   localparam int FDM_ENTRY_W = FDM_DATA_W + 2 * FDM_ADDR_W;

   // Field order matches the ROM word: mask in the MSBs, reg_addr in the LSBs.
   typedef struct packed {
      logic [FDM_DATA_W-1:0] mask;
      logic [FDM_ADDR_W-1:0] fuse_addr;
      logic [FDM_ADDR_W-1:0] reg_addr;
   } fuse_lut_element_t;

   localparam fuse_lut_element_t FUSE_LUT_EOF = '1;

   typedef logic [2:0] walker_state_t;

   localparam walker_state_t ST_IDLE = 3'd0;
   localparam walker_state_t ST_RD   = 3'd1;
   localparam walker_state_t ST_CHK  = 3'd2;
   localparam walker_state_t ST_FREQ = 3'd3;
   localparam walker_state_t ST_WR   = 3'd4;
   localparam walker_state_t ST_NEXT = 3'd5;
   localparam walker_state_t ST_DONE = 3'd6;
   localparam walker_state_t ST_ERR  = 3'd7;

endpackage

// File: rtl/caliptra_fdm_lut_rom.sv
// Fuse LUT storage: block-RAM style array with a registered read and a load port for provisioning.
module caliptra_fdm_lut_rom #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 96,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic             readen,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (load_en) begin
         mem[load_addr] <= load_data;
      end
      if (readen) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/caliptra_fdm_lut_walker.sv
// Fuse distribution sequencer: walks the fuse LUT, reads each fuse, masks it and writes the target register.
module caliptra_fdm_lut_walker
   import fuse_lut_pkg::*;
#(
   parameter int LUT_ENTRIES    = 64,
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT        = 1024,
   parameter bit SKIP_ZERO_MASK = 1'b1,
   localparam int IDX_W         = $clog2(LUT_ENTRIES),
   localparam int ENTRY_W       = DATA_W + 2 * ADDR_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic [IDX_W-1:0]   o_err_idx,
   output logic               o_lut_readen,
   output logic [IDX_W-1:0]   o_lut_raddr,
   input  logic [ENTRY_W-1:0] i_lut_rdata,
   output logic               o_fuse_req,
   output logic [ADDR_W-1:0]  o_fuse_addr,
   input  logic               i_fuse_ack,
   input  logic [DATA_W-1:0]  i_fuse_rdata,
   output logic               o_wr_valid,
   output logic [ADDR_W-1:0]  o_wr_addr,
   output logic [DATA_W-1:0]  o_wr_data,
   input  logic               i_wr_ready
);

   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_ENTRIES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   // Same layout as fuse_lut_element_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_W-1:0] mask;
      logic [ADDR_W-1:0] fuse_addr;
      logic [ADDR_W-1:0] reg_addr;
   } entry_t;

   walker_state_t     state_reg, state_next;
   logic [IDX_W-1:0]  idx_reg;
   logic [TMO_W-1:0]  tmo_reg;
   entry_t            entry_reg;
   entry_t            lut_entry;
   logic [DATA_W-1:0] wdata_reg;
   logic              done_reg;
   logic              err_reg;
   logic [IDX_W-1:0]  err_idx_reg;
   logic              tmo_hit;

   assign lut_entry = i_lut_rdata;
   assign tmo_hit   = (tmo_reg == TMO_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (i_start) state_next = ST_RD;
         ST_RD:   state_next = ST_CHK;
         ST_CHK: begin
            if (&i_lut_rdata)                                 state_next = ST_DONE;
            else if (SKIP_ZERO_MASK && (lut_entry.mask == '0)) state_next = ST_NEXT;
            else                                              state_next = ST_FREQ;
         end
         ST_FREQ: begin
            if (i_fuse_ack)   state_next = ST_WR;
            else if (tmo_hit) state_next = ST_ERR;
         end
         ST_WR: begin
            if (i_wr_ready)   state_next = ST_NEXT;
            else if (tmo_hit) state_next = ST_ERR;
         end
         ST_NEXT: state_next = (idx_reg == LAST_IDX) ? ST_DONE : ST_RD;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         tmo_reg     <= '0;
         entry_reg   <= '0;
         wdata_reg   <= '0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         err_idx_reg <= '0;
      end else begin
         state_reg <= state_next;
         // The wait counter restarts on every state change, so FREQ and WR each get a full budget.
         if (state_next != state_reg) begin
            tmo_reg <= '0;
         end else if ((state_reg == ST_FREQ) || (state_reg == ST_WR)) begin
            tmo_reg <= tmo_reg + TMO_W'(1);
         end
         case (state_reg)
            ST_IDLE: begin
               if (i_start) begin
                  done_reg <= 1'b0;
                  err_reg  <= 1'b0;
                  idx_reg  <= '0;
               end
            end
            ST_CHK:  entry_reg <= lut_entry;
            ST_FREQ: begin
               if (i_fuse_ack) wdata_reg <= i_fuse_rdata & entry_reg.mask;
            end
            ST_NEXT: begin
               if (idx_reg != LAST_IDX) idx_reg <= idx_reg + IDX_W'(1);
            end
            ST_DONE: done_reg <= 1'b1;
            ST_ERR: begin
               err_reg     <= 1'b1;
               err_idx_reg <= idx_reg;
            end
            default: ;
         endcase
      end
   end

   assign o_busy       = (state_reg != ST_IDLE);
   assign o_done       = done_reg;
   assign o_err        = err_reg;
   assign o_err_idx    = err_idx_reg;
   assign o_lut_readen = (state_reg == ST_RD);
   assign o_lut_raddr  = o_lut_readen ? idx_reg : '0;
   assign o_fuse_req   = (state_reg == ST_FREQ);
   assign o_fuse_addr  = o_fuse_req ? entry_reg.fuse_addr : '0;
   assign o_wr_valid   = (state_reg == ST_WR);
   assign o_wr_addr    = o_wr_valid ? entry_reg.reg_addr : '0;
   assign o_wr_data    = o_wr_valid ? wdata_reg : '0;

endmodule

// File: doc/caliptra_fdm_lut_walker.md
Name: caliptra_fdm_lut_walker

Overview:
- Parametrised fuse-distribution sequencer inside the FDM.
- Walks a fuse LUT stored in synchronous ROM; each entry is {mask, fuse_addr, reg_addr}.
- Per entry: reads the fuse controller over a req/ack handshake, ANDs the result with the mask, and issues one register write over valid/ready.
- Stops at the EOF sentinel or at the last entry; reports done or a timeout error with the failing entry index.

Parameters:
- LUT_ENTRIES, 64, number of LUT rows; address width is IDX_W = $clog2(LUT_ENTRIES).
- DATA_W, 32, width of the mask, fuse data and register write data.
- ADDR_W, 32, width of fuse_addr and reg_addr.
- TIMEOUT, 1024, maximum number of cycles to wait for i_fuse_ack or i_wr_ready.
- SKIP_ZERO_MASK, 1, when 1 an entry with mask==0 is skipped with no fuse read and no write.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_start  in  1  single-cycle pulse that starts a walk; ignored while o_busy.
- o_busy  out  1  walk in progress.
- o_done  out  1  sticky walk-complete flag; cleared by i_start.
- o_err  out  1  sticky timeout flag; cleared by i_start.
- o_err_idx  out  IDX_W  LUT index of the entry that timed out.
- o_lut_readen  out  1  ROM read enable.
- o_lut_raddr  out  IDX_W  ROM read address.
- i_lut_rdata  in  DATA_W+2*ADDR_W  ROM data; valid 1 cycle after o_lut_readen.
- o_fuse_req  out  1  fuse read request; held until ack.
- o_fuse_addr  out  ADDR_W  fuse address.
- i_fuse_ack  in  1  fuse read ack.
- i_fuse_rdata  in  DATA_W  fuse data; valid with i_fuse_ack.
- o_wr_valid  out  1  register write valid.
- o_wr_addr  out  ADDR_W  register write address.
- o_wr_data  out  DATA_W  register write data.
- i_wr_ready  in  1  register write ready.

Behaviour:
- Reset: every output is 0, state is IDLE, index is 0, timeout counter is 0. Reset takes effect asynchronously, including in the middle of a walk.
- IDLE:
  - On i_start: clear o_done/o_err, index := 0, go to RD.
- RD:
  - o_lut_readen=1, o_lut_raddr=index.
  - Go to CHK.
- CHK:
  - Register i_lut_rdata into the entry registers.
  - If the entry is all-ones (EOF): go to DONE.
  - Else if SKIP_ZERO_MASK and mask==0: go to NEXT.
  - Else: go to FREQ.
- FREQ:
  - o_fuse_req=1 with o_fuse_addr stable.
  - On i_fuse_ack: wdata := i_fuse_rdata & mask, go to WR.
  - Timeout counter increments each cycle without ack. When it reaches TIMEOUT-1 without ack: go to ERR.
- WR:
  - o_wr_valid=1 with addr/data stable.
  - Transfer occurs when valid&&ready; then go to NEXT.
  - Same timeout rule as FREQ.
- NEXT:
  - If index==LUT_ENTRIES-1: go to DONE.
  - Else index+1, go to RD.
- DONE:
  - o_done=1, return to IDLE.
  - o_done stays high until the next i_start.
- ERR:
  - o_err=1, o_err_idx=index, return to IDLE.
  - No further writes are issued.
- Timeout counter clears on every state entry.
- o_busy=1 in every state except IDLE.
- Ack on the same cycle as req assertion is legal: one-cycle FREQ.
- Ready already high on WR entry is legal: one-cycle WR.
- Minimum cost per written entry is 5 cycles: RD, CHK, FREQ, WR, NEXT.
- i_start while busy is ignored. i_start coincident with the return to IDLE is also ignored.
- Fuse and write outputs drive 0 when not in their own state.

Decomposition:
- fuse_lut_pkg holds:
  - parametrised fuse_lut_element_t {mask, fuse_addr, reg_addr};
  - the EOF sentinel constant;
  - the walker state enum.
- One sub-module: caliptra_fdm_lut_rom, the synchronous ROM with a 1-cycle registered read. It is instantiated by the FDM top, not inside the walker.

Test Plan:
- 3 entries {FFFF_0000,0x10,0x200}, {0000_00FF,0x14,0x204}, EOF; fuse data 0x1234_5678 and 0xAABB_CCDD; immediate ack/ready -> writes (0x200,0x1234_0000) then (0x204,0x0000_00DD); o_done=1; no third write.
- Entry with mask 0 between two valid entries, SKIP_ZERO_MASK=1 -> no o_fuse_req for that index, 2 writes. Same stimulus with SKIP_ZERO_MASK=0 -> 3 writes, the middle one with data 0.
- Full LUT_ENTRIES=4 with no EOF -> 4 writes, then o_done. o_lut_raddr never exceeds 3.
- Hold i_fuse_ack low on entry 2, TIMEOUT=16 -> o_err=1 after 16 FREQ cycles, o_err_idx=2, o_done=0, no write for entry 2.
- i_wr_ready low for 5 cycles -> o_wr_valid, addr and data held stable for all 5 cycles; a single transfer occurs.
- Assert i_rst during WR -> all outputs 0 in the same cycle. A later i_start restarts from index 0.
